// File: rtl/dtw_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dtw_pkg : constants and types shared by the dtw core and its sample feeder.
// rev 1.0
// ---------------------------------------------------------------------------
package dtw_pkg;

  localparam int DATA_WIDTH = 10;
  localparam int SIZE       = 602;
  localparam int IDX_W      = $clog2(SIZE + 1);

  typedef logic [DATA_WIDTH-1:0] sample_t;
  typedef logic [IDX_W-1:0]      idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/dtw_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dtw_sync_fifo : single-clock FIFO with occupancy count and synchronous flush.
// rev 1.0
// ---------------------------------------------------------------------------
module dtw_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == C_DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr];

  // Storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtw_sample_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dtw_sample_feeder : reference RAM + camera FIFO feeding samples to dtw.
// rev 1.0
// ---------------------------------------------------------------------------
module dtw_sample_feeder #(
  parameter int DATA_WIDTH     = dtw_pkg::DATA_WIDTH,
  parameter int SIZE           = dtw_pkg::SIZE,
  parameter int CAM_FIFO_DEPTH = 16,
  parameter int PREFILL        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ref_wr_en,
  input  logic [DATA_WIDTH-1:0] ref_wr_data,
  output logic                  ref_loaded,
  input  logic                  cam_valid,
  input  logic [DATA_WIDTH-1:0] cam_data,
  output logic                  cam_ready,
  input  logic                  start,
  input  logic                  abort,
  output logic                  ready,
  input  logic                  ready_refer,
  input  logic                  ready_camera,
  output logic [DATA_WIDTH-1:0] refer,
  output logic [DATA_WIDTH-1:0] camera,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] score,
  output logic [DATA_WIDTH-1:0] score_out,
  output logic                  score_valid,
  output logic                  busy,
  output logic                  err_underrun
);

  import dtw_pkg::*;

  localparam int            IW        = $clog2(SIZE + 1);
  localparam int            CW        = $clog2(CAM_FIFO_DEPTH + 1);
  localparam logic [IW-1:0] C_SIZE    = IW'(SIZE);
  localparam logic [CW-1:0] C_DEPTH   = CW'(CAM_FIFO_DEPTH);
  localparam logic [CW-1:0] C_PREFILL = CW'(PREFILL);

  feeder_state_t         state;
  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [IW-1:0]         wptr;
  logic [IW-1:0]         ref_idx;
  logic [IW-1:0]         cam_idx;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         count_next;

  logic ref_wr;
  logic ref_req;
  logic cam_req;
  logic push;
  logic pop;
  logic flush;
  logic start_ok;

  assign ref_wr   = (state == ST_IDLE) && ref_wr_en && (wptr != C_SIZE);
  assign ref_req  = (state == ST_RUN) && ready_refer && (ref_idx != C_SIZE);
  assign cam_req  = (state == ST_RUN) && ready_camera && (cam_idx != C_SIZE);
  assign push     = cam_valid && cam_ready && !fifo_full;
  assign pop      = cam_req && !fifo_empty;
  assign flush    = (state == ST_FINISH) || ((state == ST_RUN) && abort);
  assign start_ok = (state == ST_IDLE) && start && ref_loaded && (fifo_count >= C_PREFILL);

  // cam_ready is registered, so it is derived from next-cycle occupancy.
  assign count_next = flush ? '0 : (fifo_count + CW'(push) - CW'(pop));

  dtw_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (CAM_FIFO_DEPTH)
  ) u_cam_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .wr_data (cam_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (ref_wr) begin
      mem[wptr] <= ref_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wptr         <= '0;
      ref_idx      <= '0;
      cam_idx      <= '0;
      ref_loaded   <= 1'b0;
      cam_ready    <= 1'b0;
      ready        <= 1'b0;
      refer        <= '0;
      camera       <= '0;
      score_out    <= '0;
      score_valid  <= 1'b0;
      busy         <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      cam_ready   <= (count_next != C_DEPTH);
      score_valid <= 1'b0;

      if (ref_wr) begin
        wptr       <= wptr + 1'b1;
        ref_loaded <= (wptr == C_SIZE - 1'b1);
      end

      if (ref_req) begin
        refer   <= mem[ref_idx];
        ref_idx <= ref_idx + 1'b1;
      end

      // An empty FIFO still consumes the request slot; camera keeps its value.
      if (cam_req) begin
        cam_idx <= cam_idx + 1'b1;
        if (fifo_empty) begin
          err_underrun <= 1'b1;
        end else begin
          camera <= fifo_head;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state        <= ST_RUN;
            ready        <= 1'b1;
            busy         <= 1'b1;
            ref_idx      <= '0;
            cam_idx      <= '0;
            err_underrun <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
          end else if (done) begin
            state       <= ST_FINISH;
            ready       <= 1'b0;
            score_out   <= score;
            score_valid <= 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dtw_sample_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dtw_sample_feeder : vector table, directed corner cases and random
// stimulus checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_dtw_sample_feeder;

  localparam int DW    = 10;
  localparam int SZ    = 602;
  localparam int DEPTH = 16;
  localparam int PRE   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ref_wr_en;
  logic [DW-1:0] ref_wr_data;
  logic          ref_loaded;
  logic          cam_valid;
  logic [DW-1:0] cam_data;
  logic          cam_ready;
  logic          start;
  logic          abort;
  logic          ready;
  logic          ready_refer;
  logic          ready_camera;
  logic [DW-1:0] refer;
  logic [DW-1:0] camera;
  logic          done;
  logic [DW-1:0] score;
  logic [DW-1:0] score_out;
  logic          score_valid;
  logic          busy;
  logic          err_underrun;

  int total = 0;
  int bad   = 0;

  dtw_sample_feeder #(
    .DATA_WIDTH     (DW),
    .SIZE           (SZ),
    .CAM_FIFO_DEPTH (DEPTH),
    .PREFILL        (PRE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ref_wr_en    (ref_wr_en),
    .ref_wr_data  (ref_wr_data),
    .ref_loaded   (ref_loaded),
    .cam_valid    (cam_valid),
    .cam_data     (cam_data),
    .cam_ready    (cam_ready),
    .start        (start),
    .abort        (abort),
    .ready        (ready),
    .ready_refer  (ready_refer),
    .ready_camera (ready_camera),
    .refer        (refer),
    .camera       (camera),
    .done         (done),
    .score        (score),
    .score_out    (score_out),
    .score_valid  (score_valid),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 running, 2 finishing.
  int m_ref [SZ];
  int m_q [$];
  int m_state, m_wptr, m_ridx, m_cidx, m_refer, m_camera, m_score;
  bit m_loaded, m_cam_ready, m_ready, m_sv, m_busy, m_err;

  task automatic model_reset();
    m_q.delete();
    m_state = 0; m_wptr = 0; m_ridx = 0; m_cidx = 0;
    m_refer = 0; m_camera = 0; m_score = 0;
    m_loaded = 0; m_cam_ready = 0; m_ready = 0; m_sv = 0; m_busy = 0; m_err = 0;
  endtask

  task automatic model_step();
    int st;
    int qn;
    bit ld;
    bit cr;
    bit fl;
    st = m_state;
    qn = m_q.size();
    ld = m_loaded;
    cr = m_cam_ready;
    fl = (st == 2) || (st == 1 && abort);
    m_sv = 0;
    if (st == 0 && ref_wr_en && m_wptr < SZ) begin
      m_ref[m_wptr] = int'(ref_wr_data);
      m_wptr++;
      if (m_wptr == SZ) m_loaded = 1;
    end
    if (st == 1) begin
      if (ready_refer && m_ridx < SZ) begin
        m_refer = m_ref[m_ridx];
        m_ridx++;
      end
      if (ready_camera && m_cidx < SZ) begin
        if (m_q.size() > 0) m_camera = m_q.pop_front();
        else m_err = 1;
        m_cidx++;
      end
    end
    if (cam_valid && cr) m_q.push_back(int'(cam_data));
    if (fl) m_q.delete();
    case (st)
      0: if (start && ld && qn >= PRE) begin
           m_state = 1; m_ready = 1; m_ridx = 0; m_cidx = 0; m_err = 0;
         end
      1: if (abort) begin
           m_state = 0; m_ready = 0;
         end else if (done) begin
           m_state = 2; m_ready = 0; m_score = int'(score); m_sv = 1;
         end
      default: m_state = 0;
    endcase
    m_busy      = (m_state != 0);
    m_cam_ready = (m_q.size() != DEPTH);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("m_ref_loaded",   int'(ref_loaded),   int'(m_loaded));
    chk("m_cam_ready",    int'(cam_ready),    int'(m_cam_ready));
    chk("m_ready",        int'(ready),        int'(m_ready));
    chk("m_refer",        int'(refer),        m_refer);
    chk("m_camera",       int'(camera),       m_camera);
    chk("m_score_out",    int'(score_out),    m_score);
    chk("m_score_valid",  int'(score_valid),  int'(m_sv));
    chk("m_busy",         int'(busy),         int'(m_busy));
    chk("m_err_underrun", int'(err_underrun), int'(m_err));
  endtask

  task automatic quiet();
    ref_wr_en = 0; ref_wr_data = '0; cam_valid = 0; cam_data = '0;
    start = 0; abort = 0; ready_refer = 0; ready_camera = 0; done = 0; score = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    bit rr;
    bit rc;
    int exp_refer;
    int exp_camera;
  } vec_t;

  vec_t vt [6];

  initial begin
    int cam_next;
    int n;
    bit acc;

    // ref[i]=i, camera stream 602-i; outputs expected after each request edge
    vt[0] = '{1'b1, 1'b0, 0, 0};
    vt[1] = '{1'b1, 1'b1, 1, 602};
    vt[2] = '{1'b0, 1'b0, 1, 602};
    vt[3] = '{1'b0, 1'b1, 1, 601};
    vt[4] = '{1'b1, 1'b1, 2, 600};
    vt[5] = '{1'b1, 1'b0, 3, 600};

    quiet();
    rst = 0;
    model_reset();
    #1 rst = 1;
    #1;
    check_all();
    chk("rst_cam_ready", int'(cam_ready), 0);
    @(negedge clk);
    rst = 0;
    cyc();
    chk("cam_ready_after_rst", int'(cam_ready), 1);

    // 601 reference samples + 8 camera samples: start must be refused
    for (int i = 0; i < SZ - 1; i++) begin
      ref_wr_en = 1; ref_wr_data = DW'(i);
      cyc();
    end
    ref_wr_en = 0;
    chk("loaded_at_601", int'(ref_loaded), 0);
    for (int i = 0; i < PRE; i++) begin
      cam_valid = 1; cam_data = DW'(602 - i);
      cyc();
    end
    cam_valid = 0;
    start = 1; cyc(); start = 0;
    chk("start_ref_601", int'(ready), 0);
    chk("busy_ref_601", int'(busy), 0);
    ref_wr_en = 1; ref_wr_data = DW'(SZ - 1); cyc(); ref_wr_en = 0;
    chk("loaded_at_602", int'(ref_loaded), 1);
    start = 1; cyc(); start = 0;
    chk("start_ok_ready", int'(ready), 1);
    chk("start_ok_busy", int'(busy), 1);

    for (int i = 0; i < 6; i++) begin
      ready_refer = vt[i].rr; ready_camera = vt[i].rc;
      cyc();
      chk("vec_refer", int'(refer), vt[i].exp_refer);
      chk("vec_camera", int'(camera), vt[i].exp_camera);
    end
    quiet();

    // Stream remaining camera samples ahead of demand until both indices saturate
    cam_next = PRE;
    n = 0;
    while ((m_ridx < SZ || m_cidx < SZ) && n < 10000) begin
      cam_valid    = (cam_next < SZ);
      cam_data     = DW'(602 - cam_next);
      ready_refer  = ($urandom_range(0, 1) == 1);
      ready_camera = ($urandom_range(0, 2) != 0) && (m_q.size() > 0);
      acc = cam_valid && m_cam_ready;
      cyc();
      if (acc) cam_next++;
      n++;
    end
    quiet();
    chk("stream_within_bound", int'(n < 10000), 1);
    chk("stream_err", int'(err_underrun), 0);
    chk("last_refer", int'(refer), 601);
    chk("last_camera", int'(camera), 1);
    ready_refer = 1; ready_camera = 1; cyc(); quiet();
    chk("sat_refer", int'(refer), 601);
    chk("sat_camera", int'(camera), 1);
    chk("sat_err", int'(err_underrun), 0);

    done = 1; score = DW'(37); cyc(); quiet();
    chk("score_out", int'(score_out), 37);
    chk("score_valid_hi", int'(score_valid), 1);
    chk("done_ready", int'(ready), 0);
    cyc();
    chk("score_valid_lo", int'(score_valid), 0);
    chk("done_busy", int'(busy), 0);
    chk("done_ref_kept", int'(ref_loaded), 1);

    // Prefill threshold, then underrun on the 9th camera request
    for (int i = 0; i < PRE - 1; i++) begin
      cam_valid = 1; cam_data = DW'(100 + i); cyc();
    end
    cam_valid = 0;
    start = 1; cyc(); start = 0;
    chk("start_cnt7", int'(ready), 0);
    cam_valid = 1; cam_data = DW'(107); cyc(); cam_valid = 0;
    start = 1; cyc(); start = 0;
    chk("start_cnt8", int'(ready), 1);
    ready_camera = 1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("under_camera", int'(camera), (i < 8) ? 100 + i : 107);
      chk("under_err", int'(err_underrun), (i < 8) ? 0 : 1);
    end
    ready_camera = 0;

    // abort and done together: no score, FIFO flushed
    for (int i = 0; i < 3; i++) begin
      cam_valid = 1; cam_data = DW'(300 + i); cyc();
    end
    cam_valid = 0;
    abort = 1; done = 1; score = DW'(55); cyc(); quiet();
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(ready), 0);
    chk("abort_sv", int'(score_valid), 0);
    chk("abort_score", int'(score_out), 37);
    chk("abort_err_sticky", int'(err_underrun), 1);
    cyc();
    chk("abort_sv_next", int'(score_valid), 0);
    start = 1; cyc(); start = 0;
    chk("start_after_flush", int'(ready), 0);

    // Overfill: 20 pushes, only 16 kept
    for (int i = 0; i < 20; i++) begin
      cam_valid = 1; cam_data = DW'(200 + i); cyc();
      chk("full_cam_ready", int'(cam_ready), (i < 15) ? 1 : 0);
    end
    cam_valid = 0;
    start = 1; cyc(); start = 0;
    chk("full_start", int'(ready), 1);
    chk("start_clears_err", int'(err_underrun), 0);
    ready_camera = 1; cyc();
    chk("full_pop0", int'(camera), 200);
    chk("full_ready_back", int'(cam_ready), 1);
    for (int i = 1; i < 17; i++) begin
      cyc();
      chk("full_pop", int'(camera), (i < 16) ? 200 + i : 215);
      chk("full_err", int'(err_underrun), (i < 16) ? 0 : 1);
    end
    quiet();

    // Asynchronous reset in the middle of a run
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_ready", int'(ready), 0);
    chk("arst_loaded", int'(ref_loaded), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_camera", int'(camera), 0);
    check_all();
    @(negedge clk);
    rst = 0;

    // Randomised traffic, full model comparison each cycle
    for (int c = 0; c < 3000; c++) begin
      ref_wr_en    = ($urandom_range(0, 9) < 6);
      ref_wr_data  = DW'($urandom);
      cam_valid    = ($urandom_range(0, 1) == 1);
      cam_data     = DW'($urandom);
      start        = ($urandom_range(0, 19) == 0);
      abort        = ($urandom_range(0, 199) == 0);
      done         = ($urandom_range(0, 99) == 0);
      score        = DW'($urandom);
      ready_refer  = ($urandom_range(0, 1) == 1);
      ready_camera = ($urandom_range(0, 2) == 0);
      cyc();
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dtw_sample_feeder.md
Name: dtw_sample_feeder

Overview:
Upstream stage of the dtw core. It holds the SIZE-sample reference sequence in an internal RAM and buffers the live camera sample stream in a small FIFO. It answers dtw's ready_refer/ready_camera requests with the next sample one cycle later. It raises the start level (ready) toward dtw and latches the final score when dtw pulses done.

Parameters:
DATA_WIDTH, 10, sample and score width
SIZE, 602, samples per sequence (reference and camera)
CAM_FIFO_DEPTH, 16, camera buffer entries (power of 2)
PREFILL, 8, minimum camera FIFO occupancy before a run may start (1..CAM_FIFO_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ref_wr_en  in  1  reference load strobe; one sample per cycle
ref_wr_data  in  DATA_WIDTH  reference sample
ref_loaded  out  1  all SIZE reference samples written
cam_valid  in  1  camera sample valid
cam_data  in  DATA_WIDTH  camera sample
cam_ready  out  1  FIFO can accept (not full)
start  in  1  pulse; request a DTW run
abort  in  1  pulse; cancel run
ready  out  1  run-enable level to dtw
ready_refer  in  1  dtw requests next reference sample
ready_camera  in  1  dtw requests next camera sample
refer  out  DATA_WIDTH  reference sample to dtw
camera  out  DATA_WIDTH  camera sample to dtw
done  in  1  dtw completion pulse
score  in  DATA_WIDTH  dtw result
score_out  out  DATA_WIDTH  latched score
score_valid  out  1  one-cycle pulse when score_out updates
busy  out  1  state != IDLE
err_underrun  out  1  sticky; camera request served from empty FIFO

Behaviour:
- Reset: all outputs 0; state IDLE; write pointer, ref_idx, cam_idx and FIFO pointers cleared; ref_loaded cleared, so the reference must be reloaded. RAM contents are not reset. cam_ready rises the cycle after rst deasserts.
- Reference load: only in IDLE. Each ref_wr_en writes mem[wptr] and increments wptr. When wptr reaches SIZE, ref_loaded goes to 1 and further writes are ignored. Writes outside IDLE are ignored.
- Camera FIFO: push when cam_valid && cam_ready, in any state. cam_ready = !full, registered. There is no empty-bypass: a push and a pop in the same cycle on an empty FIFO counts as an underrun.
- FSM states: IDLE, RUN, FINISH.
- IDLE->RUN: start && ref_loaded && fifo_count>=PREFILL. Otherwise start is ignored. On entry, ready<=1 and ref_idx and cam_idx<=0.
- In RUN, reference requests: on a clock edge with ready_refer && ref_idx<SIZE, refer<=mem[ref_idx] and ref_idx++. Data is valid the cycle after the request (synchronous RAM read).
- In RUN, camera requests: on a clock edge with ready_camera && cam_idx<SIZE:
  - FIFO non-empty: camera<=head, pop, cam_idx++.
  - FIFO empty: camera holds its value, cam_idx++, err_underrun<=1.
- Requests with the index already at SIZE are ignored. refer/camera hold between requests. ready_refer and ready_camera in the same cycle are both served.
- RUN->FINISH on done: score_out<=score, ready<=0. In FINISH: score_valid=1 for exactly one cycle, FIFO is flushed, then return to IDLE. ref_loaded stays 1, so the reference can be reused.
- abort in RUN or FINISH: next state is IDLE, ready<=0, FIFO flushed, no score_valid. abort has priority over a simultaneous done. abort in IDLE has no effect.
- err_underrun is cleared only by rst or by an accepted start.
- Index widths are $clog2(SIZE+1). All arithmetic is unsigned, with no wrap: indices saturate at SIZE.

Decomposition:
- Package dtw_pkg: DATA_WIDTH, SIZE, IDX_W, the feeder state enum (IDLE/RUN/FINISH) and a sample typedef. The dtw core shares the same package.
- One sub-module: dtw_sync_fifo (parameters WIDTH and DEPTH; outputs full, empty, count; synchronous flush). Used for the camera buffer.

Test Plan:
- Load ref[i]=i for i=0..601, push camera 602-i through 8 samples, pulse start -> ready=1 next cycle. ready_refer at cycle N -> refer=0 at N+1, then 1, 2, ... on later requests. ready_camera -> camera=602, 601, ...
- Full run against dtw with camera streamed ahead of demand, done with score=37 -> score_out=37, score_valid high one cycle, ready=0, busy=0, err_underrun=0.
- start with only 601 reference writes, or with FIFO count 7 -> stays IDLE, ready=0. Then the 602nd write or 8th push, and start again -> RUN.
- Stop camera pushes after 8 and issue 9 ready_camera -> 9th request sets err_underrun=1, camera holds the 8th value, cam_idx=9.
- Push 20 samples without pops -> cam_ready=0 after the 16th is accepted, samples 17..20 are dropped, FIFO count=16. One pop -> cam_ready=1 the cycle after.
- abort and done in the same cycle during RUN -> IDLE, no score_valid, FIFO empty. Assert rst mid-RUN -> all outputs 0 immediately, ref_loaded=0.
